// File: rtl/pixel_fb_writer.sv
// Pixel-to-framebuffer writer: FIFO-buffered pixel stream into a registered write port.
// Optional macro PIXEL_CLIP_EN discards pixels outside the FB_W x FB_H frame.
module pixel_fb_writer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FB_W       = 256,
    parameter int unsigned FB_H       = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          pixel_valid,
    input  logic [7:0]                    px,
    input  logic [7:0]                    py,
    input  logic [23:0]                   pixel_color,
    input  logic                          src_done,
    output logic                          fb_we,
    output logic [15:0]                   fb_addr,
    output logic [23:0]                   fb_data,
    input  logic                          fb_ready,
    output logic                          done,
    output logic                          overflow,
    output logic [15:0]                   pix_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FB_H == 0)
    begin : g_bad_param
        $error("pixel_fb_writer: FIFO_DEPTH must be a power of two in 2..64 and FB_H nonzero");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_t;

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [23:0] rgb;
    } pix_t;

    state_t          r_state;
    pix_t            r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_we;
    logic [15:0]     r_addr;
    logic [23:0]     r_data;
    logic            r_done;
    logic            r_ovf;
    logic [15:0]     r_count;

    logic            w_clip;
    logic            w_empty;
    logic            w_full;
    logic            w_accept;
    logic            w_out_free;
    logic            w_pop;
    logic            w_bypass;
    logic            w_push;
    logic            w_drop;
    logic            w_load;
    logic            w_flush_done;
    pix_t            w_in;
    pix_t            w_src;
    logic [15:0]     w_addr;

`ifdef PIXEL_CLIP_EN
    assign w_clip = (32'(px) >= FB_W) || (32'(py) >= FB_H);
`else
    assign w_clip = 1'b0;
`endif

    always_comb begin
        w_in       = '{x: px, y: py, rgb: pixel_color};
        w_empty    = (r_level == '0);
        w_full     = (r_level == LW'(FIFO_DEPTH));
        // start takes priority: the pixel presented alongside it is not accepted
        w_accept   = pixel_valid && !w_clip && !start &&
                     (r_state == ST_RUN || r_state == ST_FLUSH);
        w_out_free = !r_we || fb_ready;
        w_pop      = w_out_free && !w_empty;
        w_bypass   = w_out_free && w_empty && w_accept;
        w_push     = w_accept && !w_bypass && (!w_full || w_pop);
        w_drop     = w_accept && w_full && !w_pop;
        w_load     = w_pop || w_bypass;
        w_src      = w_pop ? r_mem[r_rd_ptr] : w_in;
        // 16-bit arithmetic gives the address already truncated modulo 2^16
        w_addr     = 16'(w_src.y) * 16'(FB_W) + 16'(w_src.x);
        w_flush_done = (r_state == ST_FLUSH) && w_empty && !r_we && !w_accept;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_count  <= '0;
        end else if (start) begin
            r_state  <= ST_RUN;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_we     <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_count  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE:  r_state <= ST_IDLE;
                ST_RUN:   if (src_done) r_state <= ST_FLUSH;
                ST_FLUSH: begin
                    if (w_flush_done) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase

            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase

            if (w_load) begin
                r_we   <= 1'b1;
                r_addr <= w_addr;
                r_data <= w_src.rgb;
            end else if (r_we && fb_ready) begin
                r_we <= 1'b0;
            end

            if (r_we && fb_ready && r_count != '1) r_count <= r_count + 16'd1;
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    assign fb_we      = r_we;
    assign fb_addr    = r_addr;
    assign fb_data    = r_data;
    assign done       = r_done;
    assign overflow   = r_ovf;
    assign pix_count  = r_count;
    assign fifo_level = r_level;

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed, table-driven bench for pixel_fb_writer (depth 8); clip checks run when PIXEL_CLIP_EN is defined.
module tb_pixel_fb_writer;

`ifdef PIXEL_CLIP_EN
    localparam int TB_FBW = 200;
`else
    localparam int TB_FBW = 256;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        pixel_valid;
    logic [7:0]  px;
    logic [7:0]  py;
    logic [23:0] pixel_color;
    logic        src_done;
    logic        fb_we;
    logic [15:0] fb_addr;
    logic [23:0] fb_data;
    logic        fb_ready;
    logic        done;
    logic        overflow;
    logic [15:0] pix_count;
    logic [3:0]  fifo_level;

    int n_cmp = 0;
    int n_bad = 0;

    pixel_fb_writer #(.FIFO_DEPTH(8), .FB_W(TB_FBW), .FB_H(TB_FBW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pixel_valid(pixel_valid),
        .px(px), .py(py), .pixel_color(pixel_color), .src_done(src_done),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
        .done(done), .overflow(overflow), .pix_count(pix_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        vld;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [23:0] c;
        logic        sd;
        logic        rdy;
        logic        we;
        logic [15:0] addr;
        logic [23:0] data;
        logic [15:0] cnt;
        logic [3:0]  lvl;
        logic        dn;
        logic        ov;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic vld, input logic [7:0] x, input logic [7:0] y,
                         input logic [23:0] c, input logic sd, input logic rdy);
        start = st; pixel_valid = vld; px = x; py = y; pixel_color = c; src_done = sd; fb_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nw;
        int ndone;

        //          st vld x   y   c          sd rdy  we addr                    data       cnt lvl dn ov
        tbl[0]  = '{1, 0, 0,  0,  24'h0,      0, 1,   0, 16'(0),                 24'h0,      0, 0, 0, 0};
        tbl[1]  = '{0, 1, 10, 20, 24'hFF0000, 0, 1,   1, 16'(20*TB_FBW+10),      24'hFF0000, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0,  0,  24'h0,      0, 1,   0, 16'(0),                 24'h0,      1, 0, 0, 0};
        tbl[3]  = '{0, 1, 1,  0,  24'h000001, 0, 1,   1, 16'(1),                 24'h000001, 1, 0, 0, 0};
        tbl[4]  = '{0, 1, 2,  1,  24'h000002, 0, 1,   1, 16'(TB_FBW+2),          24'h000002, 2, 0, 0, 0};
        tbl[5]  = '{0, 1, 3,  2,  24'h000003, 0, 1,   1, 16'(2*TB_FBW+3),        24'h000003, 3, 0, 0, 0};
        tbl[6]  = '{0, 1, 4,  3,  24'h000004, 0, 1,   1, 16'(3*TB_FBW+4),        24'h000004, 4, 0, 0, 0};
        tbl[7]  = '{0, 0, 0,  0,  24'h0,      0, 1,   0, 16'(0),                 24'h0,      5, 0, 0, 0};
        tbl[8]  = '{0, 1, 5,  5,  24'hAAAAAA, 0, 0,   1, 16'(5*TB_FBW+5),        24'hAAAAAA, 5, 0, 0, 0};
        tbl[9]  = '{0, 1, 6,  5,  24'hBBBBBB, 0, 0,   1, 16'(5*TB_FBW+5),        24'hAAAAAA, 5, 1, 0, 0};
        tbl[10] = '{0, 0, 0,  0,  24'h0,      0, 1,   1, 16'(5*TB_FBW+6),        24'hBBBBBB, 6, 0, 0, 0};
        tbl[11] = '{0, 0, 0,  0,  24'h0,      0, 1,   0, 16'(0),                 24'h0,      7, 0, 0, 0};
        tbl[12] = '{0, 0, 0,  0,  24'h0,      1, 1,   0, 16'(0),                 24'h0,      7, 0, 0, 0};
        tbl[13] = '{0, 0, 0,  0,  24'h0,      0, 1,   0, 16'(0),                 24'h0,      7, 0, 1, 0};
        tbl[14] = '{0, 0, 0,  0,  24'h0,      0, 1,   0, 16'(0),                 24'h0,      7, 0, 0, 0};
        tbl[15] = '{0, 1, 9,  9,  24'h123456, 0, 1,   0, 16'(0),                 24'h0,      7, 0, 0, 0};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst.we",   32'(fb_we), 0);
        chk("rst.addr", 32'(fb_addr), 0);
        chk("rst.data", 32'(fb_data), 0);
        chk("rst.cnt",  32'(pix_count), 0);
        chk("rst.lvl",  32'(fifo_level), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.ovf",  32'(overflow), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].st, tbl[i].vld, tbl[i].x, tbl[i].y, tbl[i].c, tbl[i].sd, tbl[i].rdy);
            step();
            chk($sformatf("row%0d.we", i),   32'(fb_we), 32'(tbl[i].we));
            if (tbl[i].we) begin
                chk($sformatf("row%0d.addr", i), 32'(fb_addr), 32'(tbl[i].addr));
                chk($sformatf("row%0d.data", i), 32'(fb_data), 32'(tbl[i].data));
            end
            chk($sformatf("row%0d.cnt", i),  32'(pix_count), 32'(tbl[i].cnt));
            chk($sformatf("row%0d.lvl", i),  32'(fifo_level), 32'(tbl[i].lvl));
            chk($sformatf("row%0d.done", i), 32'(done), 32'(tbl[i].dn));
            chk($sformatf("row%0d.ovf", i),  32'(overflow), 32'(tbl[i].ov));
        end

        // Backpressure: 12 pixels into a stalled port, 1 held + 8 buffered + 3 dropped
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 8'(i), 8'd1, 24'h100 + 24'(i), 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (7) step();
        chk("bp.lvl",  32'(fifo_level), 8);
        chk("bp.we",   32'(fb_we), 1);
        chk("bp.addr", 32'(fb_addr), 32'(TB_FBW));
        chk("bp.data", 32'(fb_data), 32'h100);
        chk("bp.ovf",  32'(overflow), 1);
        chk("bp.cnt",  32'(pix_count), 0);
        fb_ready = 1'b1;
        nw = 0;
        for (int k = 0; k < 20; k++) begin
            if (fb_we) begin
                chk($sformatf("bp.w%0d.addr", nw), 32'(fb_addr), 32'(TB_FBW + nw));
                chk($sformatf("bp.w%0d.data", nw), 32'(fb_data), 32'h100 + 32'(nw));
                nw++;
            end
            step();
        end
        chk("bp.nwrites", 32'(nw), 9);
        chk("bp.cnt_end", 32'(pix_count), 9);
        chk("bp.lvl_end", 32'(fifo_level), 0);

        // Last pixel arrives with src_done while 3 pixels wait in the FIFO
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 8'(20 + i), 8'd2, 24'h300 + 24'(i), 0, 0);
            step();
        end
        drive(0, 1, 8'd23, 8'd2, 24'h303, 1, 0);
        step();
        chk("sd.lvl", 32'(fifo_level), 3);
        chk("sd.we",  32'(fb_we), 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        nw = 0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                ndone++;
                chk("sd.writes_at_done", 32'(nw), 4);
                chk("sd.cnt_at_done", 32'(pix_count), 4);
            end
            if (fb_we) begin
                chk($sformatf("sd.w%0d.data", nw), 32'(fb_data), 32'h300 + 32'(nw));
                nw++;
            end
            step();
        end
        chk("sd.ndone", 32'(ndone), 1);
        chk("sd.nwrites", 32'(nw), 4);

        // Restart mid-stream with a non-empty FIFO and overflow set
        drive(1, 0, 0, 0, 0, 0, 1);
        step();
        drive(0, 1, 8'd1, 8'd1, 24'h500, 0, 1);
        step();
        drive(0, 1, 8'd2, 8'd1, 24'h501, 0, 1);
        step();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 8'(30 + i), 8'd3, 24'h600 + 24'(i), 0, 0);
            step();
        end
        chk("rs.pre_lvl", 32'(fifo_level), 8);
        chk("rs.pre_ovf", 32'(overflow), 1);
        chk("rs.pre_cnt", 32'(pix_count), 1);
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        chk("rs.lvl", 32'(fifo_level), 0);
        chk("rs.we",  32'(fb_we), 0);
        chk("rs.cnt", 32'(pix_count), 0);
        chk("rs.ovf", 32'(overflow), 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("rs.stale%0d", k), 32'(fb_we), 0);
        end
        drive(0, 1, 8'd7, 8'd7, 24'h777777, 0, 1);
        step();
        chk("rs.new.we",   32'(fb_we), 1);
        chk("rs.new.addr", 32'(fb_addr), 32'(7 * TB_FBW + 7));
        chk("rs.new.data", 32'(fb_data), 32'h777777);
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        chk("rs.new.cnt", 32'(pix_count), 1);

`ifdef PIXEL_CLIP_EN
        drive(1, 0, 0, 0, 0, 0, 1);
        step();
        drive(0, 1, 8'd220, 8'd10, 24'hABCDEF, 0, 1);
        step();
        chk("clip.x.we", 32'(fb_we), 0);
        drive(0, 1, 8'd10, 8'd220, 24'hABCDEF, 0, 1);
        step();
        chk("clip.y.we", 32'(fb_we), 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        chk("clip.cnt", 32'(pix_count), 0);
        chk("clip.ovf", 32'(overflow), 0);
        drive(0, 1, 8'd199, 8'd199, 24'h000001, 0, 1);
        step();
        chk("clip.edge.we",   32'(fb_we), 1);
        chk("clip.edge.addr", 32'(fb_addr), 32'(199 * 200 + 199));
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
`endif

        // Reset abandons an in-flight write
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 1, 8'd1, 8'd1, 24'h000111, 0, 0);
        step();
        drive(0, 1, 8'd2, 8'd1, 24'h000222, 0, 0);
        step();
        chk("ar.pre_we", 32'(fb_we), 1);
        rst_n = 1'b0;
        #2;
        chk("ar.we",   32'(fb_we), 0);
        chk("ar.lvl",  32'(fifo_level), 0);
        chk("ar.addr", 32'(fb_addr), 0);
        chk("ar.data", 32'(fb_data), 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pixel_fb_writer.md
PIXEL_FB_WRITER -- requirements
Module: pixel_fb_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of pixel entries buffered; power of two, 2..64.
REQ-002 Parameter FB_W, default 256, framebuffer width in pixels; the address is py*FB_W+px.
REQ-003 clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins a new shape; clears pix_count and overflow.
REQ-006 pixel_valid  input  1  upstream pixel strobe.
REQ-007 px, py  input  8 each  pixel coordinates.
REQ-008 pixel_color  input  24  RGB888 colour of the pixel.
REQ-009 src_done  input  1  upstream shape-complete pulse.
REQ-010 fb_we  output  1  framebuffer write request.
REQ-011 fb_addr  output  16  framebuffer word address.
REQ-012 fb_data  output  24  framebuffer write data.
REQ-013 fb_ready  input  1  framebuffer accepts the write this cycle.
REQ-014 done  output  1  one-cycle pulse when all pixels of the shape are written.
REQ-015 overflow  output  1  sticky flag: a pixel was dropped.
REQ-016 pix_count  output  16  number of pixels written since start; saturates at 16'hFFFF.
REQ-017 fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, FLUSH and DONE.
REQ-019 Transitions: IDLE->RUN on start; RUN->FLUSH on src_done; FLUSH->DONE when the FIFO is empty and no write is pending; DONE->IDLE after one cycle; done=1 only in DONE.
REQ-020 In RUN or FLUSH, pixel_valid with the FIFO not full SHALL push {px,py,pixel_color}; pixels presented in IDLE or DONE are ignored.
REQ-021 When pixel_valid is high with the FIFO full and no pop in the same cycle, the pixel SHALL be dropped and overflow set; a push and a pop in the same cycle at full SHALL both succeed.
REQ-022 The output stage SHALL be a register: when it is empty or fb_we&&fb_ready, it loads the FIFO head, or the incoming pixel directly when the FIFO is empty (bypass).
REQ-023 Latency: a pixel accepted at edge N with the FIFO empty SHALL have fb_we=1 after edge N.
REQ-024 fb_we, fb_addr and fb_data SHALL hold stable until fb_ready=1.
REQ-025 fb_addr SHALL be py*FB_W+px, truncated to 16 bits.
REQ-026 pix_count SHALL increment on each cycle where fb_we&&fb_ready.
REQ-027 A pixel_valid in the same cycle as src_done SHALL be accepted, and it is included before done.
REQ-028 start arriving in any state other than IDLE SHALL flush the FIFO, drop the pending write, clear pix_count and overflow, and enter RUN.
REQ-029 Pixels SHALL be written in arrival order; FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-030 With rst_n=0: state=IDLE, FIFO empty, fifo_level=0, fb_we=0, fb_addr=0, fb_data=0, done=0, overflow=0, pix_count=0; any in-flight write is abandoned.

Configuration
REQ-031 With macro PIXEL_CLIP_EN defined, the block SHALL silently discard pixels with px>=FB_W or py>=FB_H, where FB_H is a parameter with default 256.
REQ-032 Discarded pixels SHALL NOT be counted and SHALL NOT set overflow.
REQ-033 Without PIXEL_CLIP_EN, every pixel SHALL be written and the FB_H parameter is unused.

Verification
REQ-034 Reset, start, one pixel (10,20,FF0000) with fb_ready=1: fb_we on the next cycle, fb_addr=5130, fb_data=FF0000, pix_count=1.
REQ-035 fb_ready=0 for 20 cycles while 12 pixels stream in: 8 are buffered plus 1 held in the output stage, overflow=1; after release, 9 writes in order.
REQ-036 Continuous pixel stream with fb_ready=1: one write per cycle, fifo_level stays 0.
REQ-037 Last pixel arriving with src_done while the FIFO holds 3 entries: done pulses exactly once, after the 4th write, with pix_count correct.
REQ-038 start mid-stream with the FIFO non-empty: FIFO empties, pix_count=0, overflow=0, no stale writes.
REQ-039 With PIXEL_CLIP_EN defined and FB_W=FB_H=200: pixel (220,10) produces no write and pix_count is unchanged.
